// File: rtl/mem_boot_loader.sv
// Stream-driven boot loader: fills data BRAM then instruction BRAM, stalls the core until done.
// Optional trailing checksum word enabled by defining LOADER_CHECKSUM_EN.
module mem_boot_loader #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int I_WORDS_MAX = 256,
  parameter int D_WORDS_MAX = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic                  d_init_done,
  output logic                  cpu_stall,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_LOAD_D,
    S_LOAD_I,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] L_I_MAX = 17'(I_WORDS_MAX);
  localparam logic [16:0] L_D_MAX = 17'(D_WORDS_MAX);

  state_t r_state, w_next;

  logic [15:0]           r_idx;
  logic [15:0]           r_i_cnt;
  logic [15:0]           r_d_cnt;
  logic [ADDR_WIDTH-1:0] r_i_w_addr, r_d_w_addr;
  logic [DATA_WIDTH-1:0] r_i_w_dat, r_d_w_dat;
  logic                  r_i_w_enb, r_d_w_enb;
  logic                  r_done, r_stall, r_error;

  logic        w_accept;
  logic        w_start_go;
  logic [15:0] w_hdr_i;
  logic [15:0] w_hdr_d;
  logic        w_last_d;
  logic        w_last_i;
  logic        w_acc_d;
  logic        w_acc_i;
  logic        w_stay_done;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_sum;
`endif

  // Ready is a pure decode of the state register: no path from s_valid.
  always_comb begin
    s_ready = 1'b0;
    case (r_state)
      S_HEADER, S_LOAD_D, S_LOAD_I: s_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:                      s_ready = 1'b1;
`endif
      default:                      s_ready = 1'b0;
    endcase
  end

  assign w_accept   = s_valid & s_ready;
  assign w_start_go = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
  assign w_hdr_i    = s_data[15:0];
  assign w_hdr_d    = s_data[31:16];
  assign w_last_d   = (r_idx == (r_d_cnt - 16'd1));
  assign w_last_i   = (r_idx == (r_i_cnt - 16'd1));
  assign w_acc_d    = w_accept & (r_state == S_LOAD_D);
  assign w_acc_i    = w_accept & (r_state == S_LOAD_I);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_HEADER;
      S_HEADER: begin
        if (w_accept) begin
          if ((w_hdr_i == 16'd0) || ({1'b0, w_hdr_i} > L_I_MAX) || ({1'b0, w_hdr_d} > L_D_MAX))
            w_next = S_ERR;
          else if (w_hdr_d == 16'd0)
            w_next = S_LOAD_I;
          else
            w_next = S_LOAD_D;
        end
      end
      S_LOAD_D: if (w_accept && w_last_d) w_next = S_LOAD_I;
      S_LOAD_I: begin
        if (w_accept && w_last_i) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: if (w_accept) w_next = (s_data[31:0] == r_sum) ? S_DONE : S_ERR;
`endif
      S_DONE:  if (start) w_next = S_HEADER;
      S_ERR:   if (start) w_next = S_HEADER;
      default: w_next = S_IDLE;
    endcase
  end

  // Status flags lag the DONE state by one cycle so they follow the final write pulse.
  assign w_stay_done = (r_state == S_DONE) && (w_next == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_i_cnt    <= '0;
      r_d_cnt    <= '0;
      r_i_w_addr <= '0;
      r_i_w_dat  <= '0;
      r_i_w_enb  <= 1'b0;
      r_d_w_addr <= '0;
      r_d_w_dat  <= '0;
      r_d_w_enb  <= 1'b0;
      r_done     <= 1'b0;
      r_stall    <= 1'b1;
      r_error    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_done    <= w_stay_done;
      r_stall   <= ~w_stay_done;
      r_error   <= (w_next == S_ERR);
      r_d_w_enb <= w_acc_d;
      r_i_w_enb <= w_acc_i;

      if (r_state == S_HEADER) begin
        r_idx <= '0;
        if (w_accept) begin
          r_i_cnt <= w_hdr_i;
          r_d_cnt <= w_hdr_d;
        end
      end else if (w_acc_d) begin
        r_idx <= w_last_d ? 16'd0 : r_idx + 16'd1;
      end else if (w_acc_i) begin
        r_idx <= r_idx + 16'd1;
      end

      if (w_acc_d) begin
        r_d_w_addr <= {r_idx[ADDR_WIDTH-3:0], 2'b00};
        r_d_w_dat  <= s_data;
      end
      if (w_acc_i) begin
        r_i_w_addr <= {r_idx[ADDR_WIDTH-3:0], 2'b00};
        r_i_w_dat  <= s_data;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_sum <= '0;
    else if (w_start_go)
      r_sum <= '0;
    else if (w_acc_d || w_acc_i)
      r_sum <= r_sum + s_data[31:0];
  end
`endif

  assign i_w_addr    = r_i_w_addr;
  assign i_w_dat     = r_i_w_dat;
  assign i_w_enb     = r_i_w_enb;
  assign d_w_addr    = r_d_w_addr;
  assign d_w_dat     = r_d_w_dat;
  assign d_w_enb     = r_d_w_enb;
  assign d_init_done = r_done;
  assign done        = r_done;
  assign cpu_stall   = r_stall;
  assign error       = r_error;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench for mem_boot_loader: table of load scenarios plus reset/checksum sequences.
module tb_mem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [9:0]  i_w_addr, d_w_addr;
  logic [31:0] i_w_dat, d_w_dat;
  logic        i_w_enb, d_w_enb;
  logic        d_init_done, cpu_stall, done, error;

  mem_boot_loader #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (10),
    .I_WORDS_MAX(256),
    .D_WORDS_MAX(256)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .i_w_addr   (i_w_addr),
    .i_w_dat    (i_w_dat),
    .i_w_enb    (i_w_enb),
    .d_w_addr   (d_w_addr),
    .d_w_dat    (d_w_dat),
    .d_w_enb    (d_w_enb),
    .d_init_done(d_init_done),
    .cpu_stall  (cpu_stall),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hdr;
    int unsigned nd;
    int unsigned ni;
    bit          gap;
    bit          mid_start;
    bit          exp_err;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Write-pulse recorder: only this process writes these.
  logic [31:0] got_d_addr [0:2047];
  logic [31:0] got_d_dat  [0:2047];
  logic [31:0] got_i_addr [0:2047];
  logic [31:0] got_i_dat  [0:2047];
  int got_d_n = 0;
  int got_i_n = 0;
  int n_both  = 0;

  always @(negedge clk) begin
    if (d_w_enb) begin
      if (got_d_n < 2048) begin
        got_d_addr[got_d_n] = 32'(d_w_addr);
        got_d_dat[got_d_n]  = d_w_dat;
      end
      got_d_n++;
    end
    if (i_w_enb) begin
      if (got_i_n < 2048) begin
        got_i_addr[got_i_n] = 32'(i_w_addr);
        got_i_dat[got_i_n]  = i_w_dat;
      end
      got_i_n++;
    end
    if (d_w_enb && i_w_enb) n_both++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] d_word(input int unsigned k);
    return 32'hD000_0000 + 32'(k);
  endfunction

  function automatic logic [31:0] i_word(input int unsigned k);
    return 32'h0000_0013 + (32'(k) << 7);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap, input bit poke, output bit ok);
    bit acc;
    if (gap) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = w;
    start   = poke;
    acc     = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      start = 1'b0;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    ok      = acc;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_d_enb"},  {31'd0, d_w_enb},     32'd0);
    chk({tag, "_i_enb"},  {31'd0, i_w_enb},     32'd0);
    chk({tag, "_addrs"},  {12'd0, d_w_addr, i_w_addr}, 32'd0);
    chk({tag, "_d_dat"},  d_w_dat,              32'd0);
    chk({tag, "_i_dat"},  i_w_dat,              32'd0);
    chk({tag, "_ready"},  {31'd0, s_ready},     32'd0);
    chk({tag, "_stall"},  {31'd0, cpu_stall},   32'd1);
    chk({tag, "_status"}, {29'd0, d_init_done, done, error}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int  base_d, base_i;
    bit  ok, all_ok;
    logic [31:0] sum;
    base_d = got_d_n;
    base_i = got_i_n;
    all_ok = 1'b1;
    sum    = '0;

    pulse_start();
    chk({v.name, "_start_ready"}, {31'd0, s_ready}, 32'd1);
    chk({v.name, "_start_flags"}, {28'd0, d_init_done, cpu_stall, done, error}, 32'b0100);

    send_word(v.hdr, v.gap, 1'b0, ok);
    all_ok &= ok;

    if (v.exp_err) begin
      chk({v.name, "_err_flags"}, {28'd0, d_init_done, cpu_stall, done, error}, 32'b0101);
      chk({v.name, "_err_ready"}, {31'd0, s_ready}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk({v.name, "_err_hold"}, {28'd0, d_init_done, cpu_stall, done, error}, 32'b0101);
    end else begin
      for (int unsigned k = 0; k < v.nd; k++) begin
        send_word(d_word(k), v.gap, 1'b0, ok);
        all_ok &= ok;
        sum += d_word(k);
      end
      for (int unsigned k = 0; k < v.ni; k++) begin
        send_word(i_word(k), v.gap, v.mid_start && (k == 2), ok);
        all_ok &= ok;
        sum += i_word(k);
      end
`ifdef LOADER_CHECKSUM_EN
      send_word(sum, v.gap, 1'b0, ok);
      all_ok &= ok;
`else
      chk({v.name, "_last_pulse"}, {31'd0, i_w_enb}, 32'd1);
`endif
      chk({v.name, "_done_late"}, {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      chk({v.name, "_done_flags"}, {28'd0, d_init_done, cpu_stall, done, error}, 32'b1010);
      chk({v.name, "_done_ready"}, {31'd0, s_ready}, 32'd0);
    end

    @(posedge clk); #1;
    chk({v.name, "_accepts"}, {31'd0, all_ok}, 32'd1);
    chk({v.name, "_d_count"}, 32'(got_d_n - base_d), v.exp_err ? 32'd0 : 32'(v.nd));
    chk({v.name, "_i_count"}, 32'(got_i_n - base_i), v.exp_err ? 32'd0 : 32'(v.ni));
    if (!v.exp_err) begin
      for (int unsigned k = 0; k < v.nd && (base_d + int'(k)) < got_d_n; k++) begin
        chk({v.name, "_d_addr"}, got_d_addr[base_d + int'(k)], (32'(k) * 32'd4) & 32'h3FF);
        chk({v.name, "_d_dat"},  got_d_dat[base_d + int'(k)],  d_word(k));
      end
      for (int unsigned k = 0; k < v.ni && (base_i + int'(k)) < got_i_n; k++) begin
        chk({v.name, "_i_addr"}, got_i_addr[base_i + int'(k)], (32'(k) * 32'd4) & 32'h3FF);
        chk({v.name, "_i_dat"},  got_i_dat[base_i + int'(k)],  i_word(k));
      end
    end
  endtask

  vec_t vecs [0:6];

  initial begin
    bit ok;
    vecs[0] = '{"t1_basic",   32'h0003_0010,   3,  16, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"t2_gap",     32'h0000_0004,   0,   4, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"t3_i0",      32'h0002_0000,   0,   0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{"t3_imax1",   32'h0000_0101,   0,   0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"dmax1",      32'h0101_0001,   0,   0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{"max_both",   32'h0100_0100, 256, 256, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"t6_midstart",32'h0002_0006,   2,   6, 1'b0, 1'b1, 1'b0};

    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("idle");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a data load, then a clean reload.
    pulse_start();
    send_word(32'h0003_0010, 1'b0, 1'b0, ok);
    send_word(d_word(0), 1'b0, 1'b0, ok);
    send_word(d_word(1), 1'b0, 1'b0, ok);
    chk("t4_accepts", {31'd0, ok}, 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("t4_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec(vecs[0]);

`ifdef LOADER_CHECKSUM_EN
    // 8 + 0xA + 0xC + 0x13 = 0x31
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start();
      send_word(32'h0003_0001, 1'b0, 1'b0, ok);
      send_word(32'h8,  1'b0, 1'b0, ok);
      send_word(32'hA,  1'b0, 1'b0, ok);
      send_word(32'hC,  1'b0, 1'b0, ok);
      send_word(32'h13, 1'b0, 1'b0, ok);
      send_word((pass == 0) ? 32'h31 : 32'h32, 1'b0, 1'b0, ok);
      chk("t5_accepts", {31'd0, ok}, 32'd1);
      @(posedge clk); #1;
      if (pass == 0)
        chk("t5_good", {28'd0, d_init_done, cpu_stall, done, error}, 32'b1010);
      else
        chk("t5_bad",  {28'd0, d_init_done, cpu_stall, done, error}, 32'b0101);
    end
`endif

    chk("both_enb", 32'(n_both), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
